bp_me_wb_arbiter: RTL and testbench



---
 rtl/bp_me_wb_pkg.sv | 31 +++
 rtl/bp_me_wb_rr_pick.sv | 18 +
 rtl/bp_me_wb_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_bp_me_wb_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_wb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package bp_me_wb_pkg;

  localparam int unsigned wb_addr_width_gp = 37;
  localparam int unsigned wb_data_width_gp = 64;
  localparam int unsigned wb_sel_width_gp  = wb_data_width_gp / 8;

  // Wishbone cycle-type and burst-type tags
  localparam logic [2:0] wb_cti_classic_gp = 3'b000;
  localparam logic [2:0] wb_cti_incr_gp    = 3'b010;
  localparam logic [2:0] wb_cti_end_gp     = 3'b111;
  localparam logic [1:0] wb_bte_linear_gp  = 2'b00;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_grant = 2'd1,
    e_abort = 2'd2,
    e_drain = 2'd3
  } arb_state_e;

  // Request-side fields muxed from the owning master onto the slave bus
  typedef struct packed {
    logic [wb_addr_width_gp-1:0] adr;
    logic [wb_data_width_gp-1:0] dat;
    logic [wb_sel_width_gp-1:0]  sel;
    logic                        we;
    logic [2:0]                  cti;
    logic [1:0]                  bte;
  } wb_req_s;

endpackage

// File: rtl/bp_me_wb_rr_pick.sv
// Two-way round-robin selector: on contention the master that did not own last wins.
module bp_me_wb_rr_pick
  import bp_me_wb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       owner,
  output logic       valid
);

  // Pick the lone requester, or alternate away from the last owner when both ask
  always_comb begin
    valid = |req;
    owner = req[1];
    if (&req) owner = ~last_owner;
  end

endmodule

// File: rtl/bp_me_wb_arbiter.sv
// Two-master to one-slave Wishbone arbiter with round-robin grant held for the
// whole cycle and a stall watchdog that aborts hung transfers with an error.
module bp_me_wb_arbiter
  import bp_me_wb_pkg::*;
#(
  parameter int unsigned addr_width_p     = wb_addr_width_gp,
  parameter int unsigned data_width_p     = wb_data_width_gp,
  parameter int unsigned timeout_cycles_p = 1024
)
(
  input  logic                      clk_i,
  input  logic                      reset_n_i,

  input  logic [addr_width_p-1:0]   m0_adr_i,
  input  logic [data_width_p-1:0]   m0_dat_i,
  input  logic                      m0_cyc_i,
  input  logic                      m0_stb_i,
  input  logic                      m0_we_i,
  input  logic [data_width_p/8-1:0] m0_sel_i,
  input  logic [2:0]                m0_cti_i,
  input  logic [1:0]                m0_bte_i,
  output logic                      m0_ack_o,
  output logic                      m0_err_o,
  output logic [data_width_p-1:0]   m0_dat_o,

  input  logic [addr_width_p-1:0]   m1_adr_i,
  input  logic [data_width_p-1:0]   m1_dat_i,
  input  logic                      m1_cyc_i,
  input  logic                      m1_stb_i,
  input  logic                      m1_we_i,
  input  logic [data_width_p/8-1:0] m1_sel_i,
  input  logic [2:0]                m1_cti_i,
  input  logic [1:0]                m1_bte_i,
  output logic                      m1_ack_o,
  output logic                      m1_err_o,
  output logic [data_width_p-1:0]   m1_dat_o,

  output logic [addr_width_p-1:0]   s_adr_o,
  output logic [data_width_p-1:0]   s_dat_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [data_width_p/8-1:0] s_sel_o,
  output logic [2:0]                s_cti_o,
  output logic [1:0]                s_bte_o,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic [data_width_p-1:0]   s_dat_i,

  output logic [1:0]                grant_o,
  output logic                      timeout_o
);

  localparam int unsigned sel_width_lp = data_width_p / 8;
  localparam int unsigned wd_width_lp  =
    (timeout_cycles_p > 0) ? $clog2(timeout_cycles_p + 1) : 1;
  localparam logic [wd_width_lp-1:0] wd_last_lp =
    (timeout_cycles_p > 0) ? wd_width_lp'(timeout_cycles_p - 1) : '0;
  localparam bit wd_enable_lp = (timeout_cycles_p > 0);

  arb_state_e             state_r, state_n;
  logic                   owner_r, owner_n;
  logic                   last_owner_r, last_owner_n;
  logic [wd_width_lp-1:0] wd_cnt_r, wd_cnt_n;

  logic    pick_owner, pick_valid;
  logic    own_cyc, own_stb;
  wb_req_s req0, req1, req_sel;

  bp_me_wb_rr_pick u_pick (
    .req        ({m1_cyc_i, m0_cyc_i}),
    .last_owner (last_owner_r),
    .owner      (pick_owner),
    .valid      (pick_valid)
  );

  // Bundle each master's request fields so the slave mux is a single select
  always_comb begin
    req0.adr = wb_addr_width_gp'(m0_adr_i);
    req0.dat = wb_data_width_gp'(m0_dat_i);
    req0.sel = wb_sel_width_gp'(m0_sel_i);
    req0.we  = m0_we_i;
    req0.cti = m0_cti_i;
    req0.bte = m0_bte_i;
    req1.adr = wb_addr_width_gp'(m1_adr_i);
    req1.dat = wb_data_width_gp'(m1_dat_i);
    req1.sel = wb_sel_width_gp'(m1_sel_i);
    req1.we  = m1_we_i;
    req1.cti = m1_cti_i;
    req1.bte = m1_bte_i;
  end

  assign req_sel = owner_r ? req1 : req0;
  assign own_cyc = owner_r ? m1_cyc_i : m0_cyc_i;
  assign own_stb = owner_r ? m1_stb_i : m0_stb_i;

  // State, ownership and watchdog registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= e_idle;
      owner_r      <= 1'b0;
      last_owner_r <= 1'b1;
      wd_cnt_r     <= '0;
    end else begin
      state_r      <= state_n;
      owner_r      <= owner_n;
      last_owner_r <= last_owner_n;
      wd_cnt_r     <= wd_cnt_n;
    end
  end

  // Next state plus bus muxing; slave and responses are live only while granted
  always_comb begin
    state_n      = state_r;
    owner_n      = owner_r;
    last_owner_n = last_owner_r;
    wd_cnt_n     = wd_cnt_r;
    s_adr_o      = '0;
    s_dat_o      = '0;
    s_cyc_o      = 1'b0;
    s_stb_o      = 1'b0;
    s_we_o       = 1'b0;
    s_sel_o      = '0;
    s_cti_o      = '0;
    s_bte_o      = '0;
    m0_ack_o     = 1'b0;
    m0_err_o     = 1'b0;
    m0_dat_o     = '0;
    m1_ack_o     = 1'b0;
    m1_err_o     = 1'b0;
    m1_dat_o     = '0;
    grant_o      = '0;
    timeout_o    = 1'b0;

    case (state_r)
      e_idle: begin
        wd_cnt_n = '0;
        if (pick_valid) begin
          owner_n = pick_owner;
          state_n = e_grant;
        end
      end

      e_grant: begin
        s_adr_o = addr_width_p'(req_sel.adr);
        s_dat_o = data_width_p'(req_sel.dat);
        s_sel_o = sel_width_lp'(req_sel.sel);
        s_we_o  = req_sel.we;
        s_cti_o = req_sel.cti;
        s_bte_o = req_sel.bte;
        s_cyc_o = own_cyc;
        s_stb_o = own_stb;
        grant_o = owner_r ? 2'b10 : 2'b01;
        if (owner_r) begin
          m1_ack_o = s_ack_i;
          m1_err_o = s_err_i;
          m1_dat_o = s_dat_i;
        end else begin
          m0_ack_o = s_ack_i;
          m0_err_o = s_err_i;
          m0_dat_o = s_dat_i;
        end
        // A termination in the expiry cycle wins over the abort
        if (!own_cyc) begin
          last_owner_n = owner_r;
          state_n      = e_idle;
          wd_cnt_n     = '0;
        end else if (!wd_enable_lp || !own_stb || s_ack_i || s_err_i) begin
          wd_cnt_n = '0;
        end else if (wd_cnt_r == wd_last_lp) begin
          state_n  = e_abort;
          wd_cnt_n = '0;
        end else begin
          wd_cnt_n = wd_cnt_r + wd_width_lp'(1);
        end
      end

      e_abort: begin
        timeout_o = 1'b1;
        if (owner_r) m1_err_o = 1'b1;
        else         m0_err_o = 1'b1;
        wd_cnt_n = '0;
        state_n  = e_drain;
      end

      e_drain: begin
        // Late slave terminations are swallowed until the owner lets go
        if (!own_cyc) begin
          last_owner_n = owner_r;
          state_n      = e_idle;
        end
      end

      default: state_n = e_idle;
    endcase
  end

endmodule

// File: tb/tb_bp_me_wb_arbiter.sv
// Self-checking bench for bp_me_wb_arbiter: directed vector table, corner-case
// sequences, and a randomized run against a transaction-level reference model.
module tb_bp_me_wb_arbiter;
  import bp_me_wb_pkg::*;

  localparam int unsigned aw  = 37;
  localparam int unsigned dw  = 64;
  localparam int unsigned sw  = dw / 8;
  localparam int unsigned tmo = 8;
  localparam logic [dw-1:0] rd_word = 64'hDEADBEEF_CAFEF00D;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [aw-1:0] m0_adr, m1_adr, s_adr;
  logic [dw-1:0] m0_dat, m1_dat, m0_rd, m1_rd, s_wd, s_rd;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [sw-1:0] m0_sel, m1_sel, s_sel;
  logic [2:0]    m0_cti, m1_cti, s_cti;
  logic [1:0]    m0_bte, m1_bte, s_bte;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic          s_cyc, s_stb, s_we, s_ack, s_err;
  logic [1:0]    grant;
  logic          timeout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bp_me_wb_arbiter #(
    .addr_width_p     (aw),
    .data_width_p     (dw),
    .timeout_cycles_p (tmo)
  ) dut (
    .clk_i     (clk),     .reset_n_i (rst_n),
    .m0_adr_i  (m0_adr),  .m0_dat_i  (m0_dat),  .m0_cyc_i (m0_cyc), .m0_stb_i (m0_stb),
    .m0_we_i   (m0_we),   .m0_sel_i  (m0_sel),  .m0_cti_i (m0_cti), .m0_bte_i (m0_bte),
    .m0_ack_o  (m0_ack),  .m0_err_o  (m0_err),  .m0_dat_o (m0_rd),
    .m1_adr_i  (m1_adr),  .m1_dat_i  (m1_dat),  .m1_cyc_i (m1_cyc), .m1_stb_i (m1_stb),
    .m1_we_i   (m1_we),   .m1_sel_i  (m1_sel),  .m1_cti_i (m1_cti), .m1_bte_i (m1_bte),
    .m1_ack_o  (m1_ack),  .m1_err_o  (m1_err),  .m1_dat_o (m1_rd),
    .s_adr_o   (s_adr),   .s_dat_o   (s_wd),    .s_cyc_o  (s_cyc),  .s_stb_o  (s_stb),
    .s_we_o    (s_we),    .s_sel_o   (s_sel),   .s_cti_o  (s_cti),  .s_bte_o  (s_bte),
    .s_ack_i   (s_ack),   .s_err_i   (s_err),   .s_dat_i  (s_rd),
    .grant_o   (grant),   .timeout_o (timeout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic to_check();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_adr = '0; m0_dat = '0; m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = '0; m0_cti = '0; m0_bte = '0;
    m1_adr = '0; m1_dat = '0; m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = '0; m1_cti = '0; m1_bte = '0;
    s_ack = 0; s_err = 0; s_rd = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    next();
    next();
    rst_n = 1'b1;
  endtask

  // ---------------- reference model (transaction level) ----------------
  int m_own;      // -1 when the bus is free
  bit m_abort;    // abort cycle in progress
  bit m_drain;    // owner aborted, waiting for it to drop cyc
  int m_stall;    // consecutive unterminated strobe cycles
  bit m_last;

  task automatic model_reset();
    m_own = -1; m_abort = 0; m_drain = 0; m_stall = 0; m_last = 1;
  endtask

  task automatic model_check(input int cyc_n);
    bit granted;
    logic [1:0] c, s;
    logic [aw-1:0] adr [2];
    logic [dw-1:0] wd [2];
    logic [sw-1:0] sel [2];
    logic [1:0] we;
    logic [2:0] cti [2];
    logic [1:0] bte [2];
    logic [1:0] e_ack, e_err;
    logic [dw-1:0] e_rd [2];
    string t;
    c = {m1_cyc, m0_cyc}; s = {m1_stb, m0_stb}; we = {m1_we, m0_we};
    adr[0] = m0_adr; adr[1] = m1_adr; wd[0] = m0_dat; wd[1] = m1_dat;
    sel[0] = m0_sel; sel[1] = m1_sel; cti[0] = m0_cti; cti[1] = m1_cti;
    bte[0] = m0_bte; bte[1] = m1_bte;
    granted = (m_own >= 0) && !m_abort && !m_drain;
    e_ack = '0; e_err = '0; e_rd[0] = '0; e_rd[1] = '0;
    if (granted) begin
      e_ack[m_own] = s_ack; e_err[m_own] = s_err; e_rd[m_own] = s_rd;
    end else if (m_abort) begin
      e_err[m_own] = 1'b1;
    end
    t = $sformatf("rnd%0d", cyc_n);
    check({t, ".s_cyc"}, 64'(s_cyc), granted ? 64'(c[m_own]) : 64'd0);
    check({t, ".s_stb"}, 64'(s_stb), granted ? 64'(s[m_own]) : 64'd0);
    check({t, ".s_adr"}, 64'(s_adr), granted ? 64'(adr[m_own]) : 64'd0);
    check({t, ".s_dat"}, s_wd, granted ? wd[m_own] : 64'd0);
    check({t, ".s_we"},  64'(s_we),  granted ? 64'(we[m_own]) : 64'd0);
    check({t, ".s_sel"}, 64'(s_sel), granted ? 64'(sel[m_own]) : 64'd0);
    check({t, ".s_cti"}, 64'(s_cti), granted ? 64'(cti[m_own]) : 64'd0);
    check({t, ".s_bte"}, 64'(s_bte), granted ? 64'(bte[m_own]) : 64'd0);
    check({t, ".ack"},   64'({m1_ack, m0_ack}), 64'(e_ack));
    check({t, ".err"},   64'({m1_err, m0_err}), 64'(e_err));
    check({t, ".m0_rd"}, m0_rd, e_rd[0]);
    check({t, ".m1_rd"}, m1_rd, e_rd[1]);
    check({t, ".grant"}, 64'(grant), granted ? (64'd1 << m_own) : 64'd0);
    check({t, ".timeout"}, 64'(timeout), 64'(m_abort));
  endtask

  task automatic model_update();
    logic [1:0] c, s;
    c = {m1_cyc, m0_cyc}; s = {m1_stb, m0_stb};
    if (m_own < 0) begin
      if (c != 2'b00) begin
        m_own   = (c == 2'b11) ? (m_last ? 0 : 1) : (c[1] ? 1 : 0);
        m_stall = 0;
      end
    end else if (m_abort) begin
      m_abort = 0;
      m_drain = 1;
    end else if (!c[m_own]) begin
      m_last  = (m_own == 1);
      m_own   = -1;
      m_drain = 0;
      m_stall = 0;
    end else if (!m_drain) begin
      if (s[m_own] && !s_ack && !s_err) begin
        m_stall++;
        if (m_stall == tmo) begin
          m_abort = 1;
          m_stall = 0;
        end
      end else begin
        m_stall = 0;
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic c0, s0, c1, s1, ack, err;
    logic [1:0] gnt;
    logic scyc, sstb, a0, a1, e0, e1, d0, d1;
  } vec_t;

  function automatic vec_t mk(input logic [5:0] in, input logic [1:0] g, input logic [7:0] o);
    vec_t v;
    {v.c0, v.s0, v.c1, v.s1, v.ack, v.err} = in;
    v.gnt = g;
    {v.scyc, v.sstb, v.a0, v.a1, v.e0, v.e1, v.d0, v.d1} = o;
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    logic [aw-1:0] exp_adr;
    // in = {c0 s0 c1 s1 ack err}, out = {scyc sstb a0 a1 e0 e1 d0 d1}
    tbl.push_back(mk(6'b001100, 2'b00, 8'b00000000)); // m1 alone requests
    tbl.push_back(mk(6'b001100, 2'b10, 8'b11000001));
    tbl.push_back(mk(6'b001100, 2'b10, 8'b11000001));
    tbl.push_back(mk(6'b001110, 2'b10, 8'b11010001)); // ack after 3 cycles
    tbl.push_back(mk(6'b110000, 2'b10, 8'b00000001)); // m1 drops, m0 waits
    tbl.push_back(mk(6'b111100, 2'b00, 8'b00000000)); // idle gap, m0 picked
    tbl.push_back(mk(6'b111110, 2'b01, 8'b11100010));
    tbl.push_back(mk(6'b001100, 2'b01, 8'b00000010));
    tbl.push_back(mk(6'b111100, 2'b00, 8'b00000000)); // m1 picked
    tbl.push_back(mk(6'b111110, 2'b10, 8'b11010001));
    tbl.push_back(mk(6'b110000, 2'b10, 8'b00000001));
    tbl.push_back(mk(6'b111100, 2'b00, 8'b00000000)); // m0 picked
    tbl.push_back(mk(6'b111101, 2'b01, 8'b11001010)); // err forwarded
    tbl.push_back(mk(6'b111111, 2'b01, 8'b11101010)); // ack+err both forwarded
    tbl.push_back(mk(6'b001100, 2'b01, 8'b00000010));
    tbl.push_back(mk(6'b001000, 2'b00, 8'b00000000)); // m1 cyc without stb
    tbl.push_back(mk(6'b001000, 2'b10, 8'b10000001));
    tbl.push_back(mk(6'b000000, 2'b10, 8'b00000001));
    tbl.push_back(mk(6'b000000, 2'b00, 8'b00000000));

    // Reset default: both masters requesting while held in reset
    rst_n = 1'b0;
    clear_inputs();
    m0_adr = aw'(37'h0_0000_0040); m1_adr = aw'(37'h0_0000_0100);
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    next();
    next();
    to_check();
    check("rst.s_cyc", 64'(s_cyc), 64'd0);
    check("rst.s_stb", 64'(s_stb), 64'd0);
    check("rst.s_we",  64'(s_we),  64'd0);
    check("rst.acks",  64'({m1_ack, m0_ack}), 64'd0);
    check("rst.errs",  64'({m1_err, m0_err}), 64'd0);
    check("rst.grant", 64'(grant), 64'd0);
    check("rst.timeout", 64'(timeout), 64'd0);
    rst_n = 1'b1;
    next();
    to_check();
    check("rst.first_grant", 64'(grant), 64'd1);
    check("rst.first_adr", 64'(s_adr), 64'(m0_adr));
    next();

    // Vector table
    apply_reset();
    m0_adr = aw'(37'h0_0000_0040); m1_adr = aw'(37'h0_0000_0100);
    s_rd = rd_word;
    for (int i = 0; i < tbl.size(); i++) begin
      {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err} =
        {tbl[i].c0, tbl[i].s0, tbl[i].c1, tbl[i].s1, tbl[i].ack, tbl[i].err};
      to_check();
      check($sformatf("tbl%0d.grant", i), 64'(grant), 64'(tbl[i].gnt));
      check($sformatf("tbl%0d.s_cyc", i), 64'(s_cyc), 64'(tbl[i].scyc));
      check($sformatf("tbl%0d.s_stb", i), 64'(s_stb), 64'(tbl[i].sstb));
      check($sformatf("tbl%0d.ack", i), 64'({m1_ack, m0_ack}), 64'({tbl[i].a1, tbl[i].a0}));
      check($sformatf("tbl%0d.err", i), 64'({m1_err, m0_err}), 64'({tbl[i].e1, tbl[i].e0}));
      check($sformatf("tbl%0d.m0_rd", i), m0_rd, tbl[i].d0 ? rd_word : 64'd0);
      check($sformatf("tbl%0d.m1_rd", i), m1_rd, tbl[i].d1 ? rd_word : 64'd0);
      exp_adr = (tbl[i].gnt == 2'b01) ? m0_adr : (tbl[i].gnt == 2'b10) ? m1_adr : '0;
      check($sformatf("tbl%0d.s_adr", i), 64'(s_adr), 64'(exp_adr));
      check($sformatf("tbl%0d.timeout", i), 64'(timeout), 64'd0);
      next();
    end

    // Burst hold: m0 4-beat incrementing burst while m1 waits
    apply_reset();
    m0_adr = aw'(37'h0_0000_0200); m1_adr = aw'(37'h0_0000_0300);
    m0_cyc = 1; m0_stb = 1; m0_cti = wb_cti_incr_gp; m1_cyc = 1; m1_stb = 1;
    to_check();
    check("burst.idle_grant", 64'(grant), 64'd0);
    next();
    for (int b = 0; b < 4; b++) begin
      m0_cti = (b == 3) ? wb_cti_end_gp : wb_cti_incr_gp;
      m0_adr = aw'(37'h0_0000_0200 + b);
      s_ack = 1; s_rd = 64'(b + 32'h1000);
      to_check();
      check($sformatf("burst%0d.grant", b), 64'(grant), 64'd1);
      check($sformatf("burst%0d.cti", b), 64'(s_cti), 64'(m0_cti));
      check($sformatf("burst%0d.adr", b), 64'(s_adr), 64'(m0_adr));
      check($sformatf("burst%0d.m0_ack", b), 64'(m0_ack), 64'd1);
      check($sformatf("burst%0d.m1_ack", b), 64'(m1_ack), 64'd0);
      check($sformatf("burst%0d.m0_rd", b), m0_rd, 64'(b + 32'h1000));
      next();
    end
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    to_check();
    check("burst.drop_scyc", 64'(s_cyc), 64'd0);
    next();
    to_check();
    check("burst.gap_grant", 64'(grant), 64'd0);
    next();
    to_check();
    check("burst.m1_grant", 64'(grant), 64'd2);
    check("burst.m1_adr", 64'(s_adr), 64'(m1_adr));
    next();

    // Watchdog: slave never answers m0
    apply_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    next();
    for (int k = 1; k <= tmo; k++) begin
      to_check();
      check($sformatf("wd%0d.s_cyc", k), 64'(s_cyc), 64'd1);
      check($sformatf("wd%0d.err_tmo", k), 64'({m0_err, timeout}), 64'd0);
      next();
    end
    to_check();
    check("wd.abort_scyc", 64'({s_cyc, s_stb}), 64'd0);
    check("wd.abort_m0_err", 64'(m0_err), 64'd1);
    check("wd.abort_timeout", 64'(timeout), 64'd1);
    check("wd.abort_m1_err", 64'(m1_err), 64'd0);
    next();
    s_ack = 1;
    to_check();
    check("wd.late_ack", 64'(m0_ack), 64'd0);
    check("wd.drain_err_tmo", 64'({m0_err, timeout}), 64'd0);
    check("wd.drain_scyc", 64'(s_cyc), 64'd0);
    next();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    to_check();
    check("wd.release_grant", 64'(grant), 64'd0);
    next();
    next();
    to_check();
    check("wd.m1_grant", 64'(grant), 64'd2);
    check("wd.m1_scyc", 64'(s_cyc), 64'd1);
    next();

    // Ack exactly on the expiry cycle wins, then async reset mid-transfer
    apply_reset();
    m0_cyc = 1; m0_stb = 1;
    next();
    for (int k = 1; k <= tmo; k++) begin
      s_ack = (k == tmo);
      to_check();
      check($sformatf("exp%0d.err_tmo", k), 64'({m0_err, timeout}), 64'd0);
      check($sformatf("exp%0d.ack", k), 64'(m0_ack), 64'(k == tmo));
      next();
    end
    s_ack = 0;
    to_check();
    check("exp.after_grant", 64'(grant), 64'd1);
    check("exp.after_err_tmo", 64'({m0_err, timeout}), 64'd0);
    next();
    s_ack = 1;
    to_check();
    check("areset.before_scyc", 64'(s_cyc), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset.scyc", 64'({s_cyc, s_stb}), 64'd0);
    check("areset.ack", 64'({m1_ack, m0_ack}), 64'd0);
    check("areset.grant", 64'(grant), 64'd0);
    next();
    m0_cyc = 0; m0_stb = 0;
    rst_n = 1'b1;
    to_check();
    check("areset.no_replay", 64'({m0_ack, m0_err}), 64'd0);
    next();

    // Randomized traffic against the reference model
    apply_reset();
    model_reset();
    for (int n = 0; n < 400; n++) begin
      if (!m0_cyc) m0_cyc = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 7) == 0) m0_cyc = 0;
      if (!m1_cyc) m1_cyc = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 7) == 0) m1_cyc = 0;
      m0_stb = m0_cyc && ($urandom_range(0, 3) != 0);
      m1_stb = m1_cyc && ($urandom_range(0, 3) != 0);
      m0_adr = aw'({$urandom(), $urandom()}); m1_adr = aw'({$urandom(), $urandom()});
      m0_dat = {$urandom(), $urandom()};      m1_dat = {$urandom(), $urandom()};
      m0_sel = sw'($urandom()); m1_sel = sw'($urandom());
      m0_we = 1'($urandom()); m1_we = 1'($urandom());
      m0_cti = 3'($urandom()); m1_cti = 3'($urandom());
      m0_bte = 2'($urandom()); m1_bte = 2'($urandom());
      s_ack = ($urandom_range(0, 4) == 0);
      s_err = ($urandom_range(0, 16) == 0);
      s_rd  = {$urandom(), $urandom()};
      to_check();
      model_check(n);
      model_update();
      next();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
